// File: rtl/pc_sequencer.sv
// Next-PC controller for the 5-stage MIPS32 pipeline: picks the next fetch
// address, drives the PC hold and per-stage flushes, and owns EPC/cause, the
// RUN/HANDLER state and the post-eret interrupt guard.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   pc, pc4, id_pc               current fetch address, its +4, ID address
//   stall_load_use               hazard unit IF/ID hold request
//   id_jump, id_jump_target      jump decoded in ID and its target
//   id_eret, id_illegal          eret / undefined instruction in ID
//   ex_branch_taken/_target      branch resolved taken in EX and its target
//   irq                          synchronised level interrupt request
//   pc_next, keep                next PC and PC-hold (combinational)
//   flush_if, flush_id           bubble IF/ID, ID/EX (combinational)
//   epc, cause                   saved return address and cause (registered)
//   in_handler, irq_ack          handler state and take pulse (registered)
module pc_sequencer #(
  parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
  parameter logic [31:0] EXC_VECTOR = 32'h80000008,
  parameter int unsigned GUARD      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [31:0] id_pc,
  input  logic        stall_load_use,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        id_eret,
  input  logic        id_illegal,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        irq,
  output logic [31:0] pc_next,
  output logic        keep,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        in_handler,
  output logic        irq_ack
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_IRQ     = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [3:0] GUARD_LD      = 4'(GUARD);

  state_t      state, state_nxt;
  logic [31:0] epc_nxt;
  logic [1:0]  cause_nxt;
  logic        irq_ack_nxt;
  logic [3:0]  guard_cnt, guard_nxt;

  // An interrupt is only taken when nothing in ID would be lost or
  // duplicated by redirecting IF: a stalled, jumping or eret instruction in ID
  // keeps the irq pending (it is level) until a clean cycle comes along.
  // Branch and illegal are excluded separately by priority order below.
  logic irq_take;
  assign irq_take = irq && (state == RUN) && (guard_cnt == 4'd0) &&
                    !stall_load_use && !id_jump && !id_eret;

  assign in_handler = (state == HANDLER);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      epc       <= 32'h0;
      cause     <= CAUSE_NONE;
      irq_ack   <= 1'b0;
      guard_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      epc       <= epc_nxt;
      cause     <= cause_nxt;
      irq_ack   <= irq_ack_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  // Next-state logic. A taken EX branch squashes whatever is in ID, so none
  // of the ID-stage events may touch architectural state in that cycle.
  always_comb begin
    state_nxt   = state;
    epc_nxt     = epc;
    cause_nxt   = cause;
    irq_ack_nxt = 1'b0;
    guard_nxt   = (guard_cnt != 4'd0) ? guard_cnt - 4'd1 : 4'd0;

    if (ex_branch_taken) begin
      // redirect only
    end else if (id_illegal) begin
      state_nxt = HANDLER;
      cause_nxt = CAUSE_ILLEGAL;
      // A fault inside the handler must not clobber the original return address.
      if (state == RUN) epc_nxt = id_pc;
    end else if (irq_take) begin
      state_nxt   = HANDLER;
      cause_nxt   = CAUSE_IRQ;
      epc_nxt     = pc;
      irq_ack_nxt = 1'b1;
    end else if (id_eret) begin
      // eret in RUN degenerates to a jump to epc but still arms the guard.
      state_nxt = RUN;
      cause_nxt = CAUSE_NONE;
      guard_nxt = GUARD_LD;
    end
  end

  // Output logic (combinational redirect / hold / flush).
  always_comb begin
    pc_next  = pc4;
    keep     = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;

    if (ex_branch_taken) begin
      pc_next  = ex_branch_target;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (id_illegal) begin
      pc_next  = EXC_VECTOR;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (irq_take) begin
      pc_next  = IRQ_VECTOR;
      flush_if = 1'b1;
    end else if (id_eret) begin
      pc_next  = epc;
      flush_if = 1'b1;
    end else if (id_jump) begin
      pc_next  = id_jump_target;
      flush_if = 1'b1;
    end else if (stall_load_use) begin
      pc_next  = pc;
      keep     = 1'b1;
      flush_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] id_pc;
  logic        stall_load_use;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic        id_eret;
  logic        id_illegal;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        irq;
  logic [31:0] pc_next;
  logic        keep;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        in_handler;
  logic        irq_ack;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .pc4              (pc4),
    .id_pc            (id_pc),
    .stall_load_use   (stall_load_use),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .id_eret          (id_eret),
    .id_illegal       (id_illegal),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .irq              (irq),
    .pc_next          (pc_next),
    .keep             (keep),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .epc              (epc),
    .cause            (cause),
    .in_handler       (in_handler),
    .irq_ack          (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pc(input logic [31:0] a);
    pc  = a;
    pc4 = a + 32'd4;
  endtask

  task automatic clear_req();
    stall_load_use   = 1'b0;
    id_jump          = 1'b0;
    id_jump_target   = 32'h0;
    id_eret          = 1'b0;
    id_illegal       = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'h0;
    id_pc            = 32'h0;
  endtask

  // Advance to the next falling edge (registered state settled), then let
  // the caller drive inputs and check combinational outputs after #1.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic chk_flow(input string tag, input logic [31:0] exp_pc, input logic exp_keep,
                          input logic exp_fif, input logic exp_fid);
    chk({tag, ".pc_next"},  pc_next,         exp_pc);
    chk({tag, ".keep"},     {31'h0, keep},     {31'h0, exp_keep});
    chk({tag, ".flush_if"}, {31'h0, flush_if}, {31'h0, exp_fif});
    chk({tag, ".flush_id"}, {31'h0, flush_id}, {31'h0, exp_fid});
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] exp_epc, input logic [1:0] exp_cause,
                          input logic exp_inh, input logic exp_ack);
    chk({tag, ".epc"},        epc,                  exp_epc);
    chk({tag, ".cause"},      {30'h0, cause},       {30'h0, exp_cause});
    chk({tag, ".in_handler"}, {31'h0, in_handler},  {31'h0, exp_inh});
    chk({tag, ".irq_ack"},    {31'h0, irq_ack},     {31'h0, exp_ack});
  endtask

  initial begin
    rst = 1'b1;
    irq = 1'b0;
    clear_req();
    set_pc(32'h00000100);
    #2;
    chk_regs("reset", 32'h0, 2'b00, 1'b0, 1'b0);

    // Free run after reset.
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_pc(32'h00000100 + 32'(4 * i));
      #1;
      chk_flow("freerun", 32'h00000104 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      chk_regs("freerun", 32'h0, 2'b00, 1'b0, 1'b0);
    end

    // Branch wins over a simultaneous load-use stall.
    next_cycle();
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h00000040;
    stall_load_use   = 1'b1;
    #1;
    chk_flow("br_stall", 32'h00000040, 1'b0, 1'b1, 1'b1);

    // Plain stall holds the PC.
    next_cycle();
    clear_req();
    set_pc(32'h00000040);
    stall_load_use = 1'b1;
    #1;
    chk_flow("stall", 32'h00000040, 1'b1, 1'b0, 1'b1);
    chk_regs("stall", 32'h0, 2'b00, 1'b0, 1'b0);

    // eret in RUN: plain jump to epc (0), guard still armed.
    next_cycle();
    clear_req();
    id_eret = 1'b1;
    #1;
    chk_flow("eret_run", 32'h0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    clear_req();
    irq = 1'b1;
    set_pc(32'h00000000);
    #1;
    chk_regs("eret_run", 32'h0, 2'b00, 1'b0, 1'b0);
    chk_flow("guard_run1", 32'h00000004, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_pc(32'h00000004);
    #1;
    chk_flow("guard_run2", 32'h00000008, 1'b0, 1'b0, 1'b0);

    // Guard expired but a jump in ID blocks the interrupt.
    next_cycle();
    set_pc(32'h00000008);
    id_jump        = 1'b1;
    id_jump_target = 32'h00000200;
    #1;
    chk_flow("jump_irq", 32'h00000200, 1'b0, 1'b1, 1'b0);

    // Interrupt taken at pc=0x10.
    next_cycle();
    clear_req();
    chk_regs("jump_irq", 32'h0, 2'b00, 1'b0, 1'b0);
    set_pc(32'h00000010);
    #1;
    chk_flow("irq", 32'h80000004, 1'b0, 1'b1, 1'b0);
    next_cycle();
    set_pc(32'h80000004);
    #1;
    chk_regs("irq_taken", 32'h00000010, 2'b01, 1'b1, 1'b1);
    // irq still high but masked in HANDLER.
    chk_flow("irq_masked", 32'h80000008, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_pc(32'h80000008);
    #1;
    chk_regs("irq_ack_pulse", 32'h00000010, 2'b01, 1'b1, 1'b0);

    // eret with irq held high: guard of 2 cycles, taken on the 3rd RUN cycle.
    id_eret = 1'b1;
    #1;
    chk_flow("eret", 32'h00000010, 1'b0, 1'b1, 1'b0);
    next_cycle();
    clear_req();
    set_pc(32'h00000010);
    #1;
    chk_regs("eret_done", 32'h00000010, 2'b00, 1'b0, 1'b0);
    chk_flow("guard1", 32'h00000014, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_pc(32'h00000014);
    #1;
    chk_flow("guard2", 32'h00000018, 1'b0, 1'b0, 1'b0);
    next_cycle();
    set_pc(32'h00000018);
    #1;
    chk_flow("irq_after_guard", 32'h80000004, 1'b0, 1'b1, 1'b0);
    next_cycle();
    irq = 1'b0;
    set_pc(32'h80000004);
    #1;
    chk_regs("irq2_taken", 32'h00000018, 2'b01, 1'b1, 1'b1);

    // Return to RUN, then an illegal instruction.
    id_eret = 1'b1;
    #1;
    chk_flow("eret2", 32'h00000018, 1'b0, 1'b1, 1'b0);
    next_cycle();
    clear_req();
    set_pc(32'h00000028);
    id_pc      = 32'h00000024;
    id_illegal = 1'b1;
    stall_load_use = 1'b1;
    #1;
    chk_regs("eret2_done", 32'h00000018, 2'b00, 1'b0, 1'b0);
    chk_flow("illegal", 32'h80000008, 1'b0, 1'b1, 1'b1);
    next_cycle();
    clear_req();
    set_pc(32'h80000008);
    #1;
    chk_regs("illegal_taken", 32'h00000024, 2'b10, 1'b1, 1'b0);

    // Second illegal in HANDLER preserves epc.
    id_pc      = 32'h00000099;
    id_illegal = 1'b1;
    #1;
    chk_flow("illegal2", 32'h80000008, 1'b0, 1'b1, 1'b1);
    next_cycle();
    clear_req();
    #1;
    chk_regs("illegal2_taken", 32'h00000024, 2'b10, 1'b1, 1'b0);

    // Branch in HANDLER does not change state.
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h00000300;
    id_eret          = 1'b1;
    #1;
    chk_flow("br_eret", 32'h00000300, 1'b0, 1'b1, 1'b1);
    next_cycle();
    clear_req();
    #1;
    chk_regs("br_eret", 32'h00000024, 2'b10, 1'b1, 1'b0);

    // Asynchronous reset between edges while in HANDLER.
    #1;
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 32'h0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    set_pc(32'h00000100);
    #1;
    chk_regs("post_rst", 32'h0, 2'b00, 1'b0, 1'b0);
    chk_flow("post_rst", 32'h00000104, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 5-stage MIPS32 pipeline. Each cycle it arbitrates between sequential fetch, ID-stage jumps, EX-stage branches, load-use stalls, illegal-instruction exceptions, external interrupts and `eret`. It drives the PC register's next-value and hold inputs plus the per-stage flush lines. It also owns the EPC/cause state, the run/handler state machine and the post-`eret` interrupt guard.

## Interface
- `IRQ_VECTOR`, default 32'h80000004, PC loaded when an interrupt is taken
- `EXC_VECTOR`, default 32'h80000008, PC loaded on an illegal instruction
- `GUARD`, default 2, cycles after `eret` during which `irq` is ignored (range 1..15)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  32  current PC register value (IF instruction address)
- `pc4`  in  32  `pc + 4`
- `id_pc`  in  32  address of the instruction in ID
- `stall_load_use`  in  1  hazard unit requests an IF/ID hold
- `id_jump`  in  1  j/jal/jr/jalr decoded in ID
- `id_jump_target`  in  32  jump target
- `id_eret`  in  1  eret decoded in ID
- `id_illegal`  in  1  undefined opcode/funct in ID
- `ex_branch_taken`  in  1  branch resolved taken in EX
- `ex_branch_target`  in  32  branch target
- `irq`  in  1  level interrupt request, already synchronised to `clk`
- `pc_next`  out  32  next PC, combinational
- `keep`  out  1  hold the PC register, combinational
- `flush_if`  out  1  bubble IF/ID, combinational
- `flush_id`  out  1  bubble ID/EX, combinational
- `epc`  out  32  saved return address, registered
- `cause`  out  2  00 none, 01 irq, 10 illegal; registered
- `in_handler`  out  1  state == HANDLER, registered
- `irq_ack`  out  1  one-cycle pulse when an interrupt is taken, registered

## Operation
- **States.**
  - RUN: interrupts enabled.
  - HANDLER: interrupts masked.
  - A separate 4-bit `guard_cnt` counts the post-`eret` holdoff.
- **Per-cycle priority (first match wins).** For every event, signals not listed are 0.
  1. `ex_branch_taken`: `pc_next`=`ex_branch_target`, `flush_if`=1, `flush_id`=1. State unchanged.
  2. `id_illegal`: `pc_next`=`EXC_VECTOR`, `flush_if`=1, `flush_id`=1.
     - Next edge: state→HANDLER, `cause`←10.
     - `epc`←`id_pc` only if the state was RUN; in HANDLER `epc` is preserved.
  3. Interrupt taken, i.e. `irq`=1, state RUN, `guard_cnt`=0, `stall_load_use`=0, `id_jump`=0, `id_eret`=0:
     - `pc_next`=`IRQ_VECTOR`, `flush_if`=1.
     - Next edge: `epc`←`pc`, `cause`←01, state→HANDLER, `irq_ack`←1.
  4. `id_eret`: `pc_next`=`epc`, `flush_if`=1.
     - Next edge: state→RUN, `cause`←00, `guard_cnt`←`GUARD`.
     - `id_eret` in RUN is treated as a plain jump to `epc`. State stays RUN and `guard_cnt` still loads.
  5. `id_jump`: `pc_next`=`id_jump_target`, `flush_if`=1.
  6. `stall_load_use`: `keep`=1, `flush_id`=1, `pc_next`=`pc`.
  7. Otherwise: `pc_next`=`pc4`, `keep`=0, no flushes.
- **Rules.**
  - `keep` is 1 only in case 6. Every redirect overrides a simultaneous stall.
  - `guard_cnt` decrements each cycle while nonzero, saturating at 0.
  - `irq` arriving while in HANDLER or while guarded stays pending (it is level). It is taken at the first eligible RUN cycle.
  - `irq_ack` is 0 in every cycle other than the one following a taken interrupt.
  - Addresses pass through unmodified. There are no alignment checks.

## Timing
- **Reset values:** state RUN, `epc`=0, `cause`=00, `in_handler`=0, `irq_ack`=0, `guard_cnt`=0. These apply asynchronously on `rst` rise and hold until the first edge after `rst` falls.
- **Combinational outputs:** zero-cycle latency from inputs. The PC register loads `pc_next` on the same edge.
- **Redirect penalty:**
  - EX branch: 2 flushed instructions.
  - ID jump, eret, interrupt: 1 flushed instruction.
- **Register updates:** `epc`, `cause`, `in_handler` update on the edge that loads the vector. They are visible in the cycle the vector is fetched.
- **Interrupt latency:** `irq` high in an eligible cycle → vector in `pc` at the next edge.
- **Reset mid-handler:** state→RUN and `epc` is lost. No special sequencing is required.

## Test plan
- **Reset then free run:** `rst` pulse, no requests. Required: `pc_next`=`pc4` every cycle, `keep`=0, `epc`=0, `cause`=00, `in_handler`=0.
- **Branch + load-use stall together:** `ex_branch_taken`=1 with target 32'h00000040 and `stall_load_use`=1. Required: `pc_next`=32'h40, `keep`=0, `flush_if`=1, `flush_id`=1.
- **Interrupt:** `irq`=1 in RUN with `pc`=32'h00000010, no other requests.
  - Required: `pc_next`=32'h80000004, `flush_if`=1.
  - Next cycle: `epc`=32'h10, `cause`=01, `in_handler`=1, `irq_ack`=1 for exactly one cycle.
- **eret with irq held high:**
  - eret in HANDLER: `pc_next`=`epc`=32'h10. Next cycle: `in_handler`=0.
  - With `irq` still 1 and `GUARD`=2, the interrupt is not taken for 2 cycles. It is taken on the 3rd RUN cycle.
- **Illegal instruction:**
  - `id_illegal`=1 with `id_pc`=32'h00000024 in RUN. Required: `pc_next`=32'h80000008, `flush_if`=1, `flush_id`=1. Next cycle: `epc`=32'h24, `cause`=10.
  - A second illegal instruction in HANDLER leaves `epc`=32'h24.
- **Async reset mid-handler:** assert `rst` between clock edges while in HANDLER. Required: `in_handler`, `epc`, `cause` clear immediately, before the next edge.
